// File: rtl/bram_bridge_pkg.sv
// bram_bridge_pkg: shared state encoding and RAM byte-lane constants for the bus bridge.
`default_nettype none

package bram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    C1   = 3'd2,
    P2   = 3'd3,
    C2   = 3'd4,
    ACK  = 3'd5
  } state_e;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/bram_lane_steer.sv
// bram_lane_steer: maps a byte-addressed request and phase onto RAM addr/be/wdata,
// and maps RAM read data back onto right-justified result bytes.
`default_nettype none

module bram_lane_steer
  import bram_bridge_pkg::*;
#(
  parameter int WORDS     = 16,
  parameter int ADDR_BITS = $clog2(WORDS)
) (
  input  logic [ADDR_BITS:0]   req_addr_i,
  input  logic [15:0]          req_data_i,
  input  logic                 req_byte_i,
  input  logic                 iss_phase2_i,
  input  logic                 cap_phase2_i,
  input  logic [15:0]          ram_q_i,
  output logic                 split_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [1:0]           be_o,
  output logic [15:0]          wdata_o,
  output logic [15:0]          result_o
);

  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(WORDS - 1);

  logic [ADDR_BITS-1:0] word_idx;
  logic                 odd;

  assign word_idx = req_addr_i[ADDR_BITS:1];
  assign odd      = req_addr_i[0];
  assign split_o  = !req_byte_i && odd;

  always_comb begin
    addr_o  = word_idx;
    be_o    = BE_WORD;
    wdata_o = req_data_i;
    if (iss_phase2_i) begin
      // Second half of a split word: upper data byte lands in the low lane of the next word.
      addr_o  = (word_idx == LAST_WORD) ? '0 : word_idx + ADDR_BITS'(1);
      be_o    = BE_LO;
      wdata_o = {8'h00, req_data_i[15:8]};
    end else if (odd) begin
      be_o    = BE_HI;
      wdata_o = {req_data_i[7:0], 8'h00};
    end else if (req_byte_i) begin
      be_o    = BE_LO;
      wdata_o = {8'h00, req_data_i[7:0]};
    end
  end

  always_comb begin
    if (cap_phase2_i) begin
      result_o = {ram_q_i[7:0], 8'h00};
    end else if (odd) begin
      result_o = {8'h00, ram_q_i[15:8]};
    end else if (req_byte_i) begin
      result_o = {8'h00, ram_q_i[7:0]};
    end else begin
      result_o = ram_q_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_bus_bridge.sv
// bram_bus_bridge: byte-addressed access/ack bus to 16-bit BlockRam port bridge;
// odd-address word accesses are split into two RAM phases.
`default_nettype none

module bram_bus_bridge
  import bram_bridge_pkg::*;
#(
  parameter int WORDS = 16,
  localparam int ADDR_BITS = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS:0]   m_addr,
  input  logic [15:0]          m_data_in,
  output logic [15:0]          m_data_out,
  input  logic                 m_access,
  input  logic                 m_wr_en,
  input  logic                 m_bytesel,
  output logic                 m_ack,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_wr_en,
  output logic [1:0]           ram_be,
  output logic [15:0]          ram_wdata,
  input  logic [15:0]          ram_q
);

  state_e               state_q, state_d;
  logic [ADDR_BITS:0]   addr_q, addr_d;
  logic [15:0]          data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 byte_q, byte_d;
  logic [7:0]           hold_q, hold_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic                 ram_wr_en_q, ram_wr_en_d;
  logic [1:0]           ram_be_q, ram_be_d;
  logic [15:0]          ram_wdata_q, ram_wdata_d;
  logic                 m_ack_q, m_ack_d;
  logic [15:0]          m_data_out_q, m_data_out_d;

  logic [ADDR_BITS:0]   req_addr;
  logic [15:0]          req_data;
  logic                 req_byte;
  logic                 split;
  logic [ADDR_BITS-1:0] steer_addr;
  logic [1:0]           steer_be;
  logic [15:0]          steer_wdata;
  logic [15:0]          steer_result;

  // In IDLE the phase-1 RAM signals come straight from the bus so they can register on acceptance.
  assign req_addr = (state_q == IDLE) ? m_addr    : addr_q;
  assign req_data = (state_q == IDLE) ? m_data_in : data_q;
  assign req_byte = (state_q == IDLE) ? m_bytesel : byte_q;

  bram_lane_steer #(
    .WORDS     (WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_steer (
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_byte_i   (req_byte),
    .iss_phase2_i (state_q == C1),
    .cap_phase2_i (state_q == C2),
    .ram_q_i      (ram_q),
    .split_o      (split),
    .addr_o       (steer_addr),
    .be_o         (steer_be),
    .wdata_o      (steer_wdata),
    .result_o     (steer_result)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    byte_d       = byte_q;
    hold_d       = hold_q;
    ram_addr_d   = ram_addr_q;
    ram_wr_en_d  = ram_wr_en_q;
    ram_be_d     = ram_be_q;
    ram_wdata_d  = ram_wdata_q;
    m_ack_d      = m_ack_q;
    m_data_out_d = m_data_out_q;
    case (state_q)
      IDLE: begin
        if (m_access) begin
          addr_d      = m_addr;
          data_d      = m_data_in;
          wr_d        = m_wr_en;
          byte_d      = m_bytesel;
          ram_addr_d  = steer_addr;
          ram_be_d    = steer_be;
          ram_wdata_d = steer_wdata;
          ram_wr_en_d = m_wr_en;
          state_d     = P1;
        end
      end
      P1: begin
        ram_wr_en_d = 1'b0;
        state_d     = C1;
      end
      C1: begin
        if (split) begin
          if (!wr_q) begin
            hold_d = steer_result[7:0];
          end
          ram_addr_d  = steer_addr;
          ram_be_d    = steer_be;
          ram_wdata_d = steer_wdata;
          ram_wr_en_d = wr_q;
          state_d     = P2;
        end else begin
          if (!wr_q) begin
            m_data_out_d = steer_result;
          end
          m_ack_d = 1'b1;
          state_d = ACK;
        end
      end
      P2: begin
        ram_wr_en_d = 1'b0;
        state_d     = C2;
      end
      C2: begin
        if (!wr_q) begin
          m_data_out_d = {steer_result[15:8], hold_q};
        end
        m_ack_d = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        m_ack_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      byte_q       <= 1'b0;
      hold_q       <= '0;
      ram_addr_q   <= '0;
      ram_wr_en_q  <= 1'b0;
      ram_be_q     <= '0;
      ram_wdata_q  <= '0;
      m_ack_q      <= 1'b0;
      m_data_out_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      byte_q       <= byte_d;
      hold_q       <= hold_d;
      ram_addr_q   <= ram_addr_d;
      ram_wr_en_q  <= ram_wr_en_d;
      ram_be_q     <= ram_be_d;
      ram_wdata_q  <= ram_wdata_d;
      m_ack_q      <= m_ack_d;
      m_data_out_q <= m_data_out_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wr_en  = ram_wr_en_q;
  assign ram_be     = ram_be_q;
  assign ram_wdata  = ram_wdata_q;
  assign m_ack      = m_ack_q;
  assign m_data_out = m_data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_bus_bridge.sv
// tb_bram_bus_bridge: directed bench for bram_bus_bridge against a byte-addressed memory model,
// with a simple 16x16 byte-enabled RAM attached to the bridge's RAM port.
`default_nettype none

module tb_bram_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [15:0] m_data_in = '0;
  logic [15:0] m_data_out;
  logic        m_access = 1'b0;
  logic        m_wr_en = 1'b0;
  logic        m_bytesel = 1'b0;
  logic        m_ack;
  logic [3:0]  ram_addr;
  logic        ram_wr_en;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata;
  logic [15:0] ram_q = '0;

  int n_vec = 0;
  int n_err = 0;

  bram_bus_bridge #(.WORDS(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_access   (m_access),
    .m_wr_en    (m_wr_en),
    .m_bytesel  (m_bytesel),
    .m_ack      (m_ack),
    .ram_addr   (ram_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Attached RAM: registered read, byte-enabled write.
  logic [15:0] ram [16];
  initial for (int i = 0; i < 16; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_wr_en) begin
      if (ram_be[0]) ram[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) ram[ram_addr][15:8] <= ram_wdata[15:8];
    end
    ram_q <= ram[ram_addr];
  end

  // Reference model: a flat little-endian byte memory, 32 bytes, wrapping.
  logic [7:0] mem_b [32];
  initial for (int i = 0; i < 32; i++) mem_b[i] = '0;

  logic        chk_en = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_we = 1'b0;
  logic        exp_issue = 1'b0;
  logic [15:0] exp_dout = '0;
  logic [3:0]  exp_raddr = '0;
  logic [1:0]  exp_be = '0;
  logic [15:0] exp_wdata = '0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_ack", 16'(m_ack), 16'(exp_ack));
      cmp("ram_wr_en", 16'(ram_wr_en), 16'(exp_we));
      cmp("m_data_out", m_data_out, exp_dout);
      if (exp_issue) begin
        cmp("ram_addr", 16'(ram_addr), 16'(exp_raddr));
        cmp("ram_be", 16'(ram_be), 16'(exp_be));
        if (exp_we) cmp("ram_wdata", ram_wdata, exp_wdata);
      end
    end
  end

  // One bus access starting with the DUT idle; keep=1 leaves m_access high through ACK.
  task automatic access(input logic [4:0] a, input logic [15:0] d, input logic wr,
                        input logic bs, input logic keep);
    logic        split;
    int          lat;
    logic [15:0] rd;
    int          w;
    split = !bs && a[0];
    lat   = split ? 4 : 2;
    w     = int'(a) / 2;
    rd    = bs ? {8'h00, mem_b[a]} : {mem_b[(int'(a) + 1) % 32], mem_b[a]};
    if (wr) begin
      mem_b[a] = d[7:0];
      if (!bs) mem_b[(int'(a) + 1) % 32] = d[15:8];
    end
    m_addr = a; m_data_in = d; m_wr_en = wr; m_bytesel = bs; m_access = 1'b1;
    for (int k = 0; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        m_addr = 5'($urandom); m_data_in = 16'($urandom);
        m_wr_en = 1'($urandom); m_bytesel = 1'($urandom);
        exp_raddr = 4'(w);
        if (a[0]) begin
          exp_be = 2'b10; exp_wdata = {d[7:0], 8'h00};
        end else if (bs) begin
          exp_be = 2'b01; exp_wdata = {8'h00, d[7:0]};
        end else begin
          exp_be = 2'b11; exp_wdata = d;
        end
      end
      if (k == 2 && split) begin
        exp_raddr = 4'((w + 1) % 16);
        exp_be    = 2'b01;
        exp_wdata = {8'h00, d[15:8]};
      end
      exp_issue = (k == 0) || (split && k == 2);
      exp_we    = wr && exp_issue;
      exp_ack   = (k == lat);
      if (k == lat && !wr) exp_dout = rd;
      if (k == lat + 1 && !keep) m_access = 1'b0;
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] exp);
    cmp(nm, m_data_out, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("rst m_ack", 16'(m_ack), 16'h0);
    cmp("rst ram_wr_en", 16'(ram_wr_en), 16'h0);
    cmp("rst ram_addr", 16'(ram_addr), 16'h0);
    cmp("rst ram_be", 16'(ram_be), 16'h0);
    cmp("rst ram_wdata", ram_wdata, 16'h0);
    cmp("rst m_data_out", m_data_out, 16'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // aligned word write/read
    access(5'h04, 16'hABCD, 1'b1, 1'b0, 1'b0);
    access(5'h04, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t1 word rd 04", 16'hABCD);

    // byte lanes
    access(5'h08, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    access(5'h09, 16'h0012, 1'b1, 1'b1, 1'b0);
    access(5'h08, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t2 word rd 08", 16'h12FF);
    access(5'h09, 16'h0000, 1'b0, 1'b1, 1'b0);
    lit("t2 byte rd 09", 16'h0012);
    access(5'h08, 16'h0000, 1'b0, 1'b1, 1'b0);
    lit("t2 byte rd 08", 16'h00FF);

    // split word
    access(5'h0A, 16'h0000, 1'b1, 1'b0, 1'b0);
    access(5'h0C, 16'h0000, 1'b1, 1'b0, 1'b0);
    access(5'h0B, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    access(5'h0A, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t3 word rd 0A", 16'hEF00);
    access(5'h0C, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t3 word rd 0C", 16'h00BE);
    access(5'h0B, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t3 word rd 0B", 16'hBEEF);

    // wrap from last word to word 0
    access(5'h1F, 16'h1234, 1'b1, 1'b0, 1'b0);
    access(5'h1E, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t4 word rd 1E", 16'h3400);
    access(5'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t4 word rd 00", 16'h0012);
    access(5'h1F, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t4 word rd 1F", 16'h1234);

    // reset during C1 of a split write
    access(5'h02, 16'h0000, 1'b1, 1'b0, 1'b0);
    access(5'h04, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b0;
    m_addr = 5'h03; m_data_in = 16'h5678; m_wr_en = 1'b1; m_bytesel = 1'b0; m_access = 1'b1;
    @(posedge clk); #1;
    m_access = 1'b0;
    @(posedge clk); #1;
    mem_b[3] = 8'h78;
    #3 reset_n = 1'b0;
    #1;
    cmp("t5 m_ack", 16'(m_ack), 16'h0);
    cmp("t5 ram_wr_en", 16'(ram_wr_en), 16'h0);
    cmp("t5 ram_addr", 16'(ram_addr), 16'h0);
    cmp("t5 ram_be", 16'(ram_be), 16'h0);
    cmp("t5 m_data_out", m_data_out, 16'h0);
    @(posedge clk); #1;
    cmp("t5 hold ram_wr_en", 16'(ram_wr_en), 16'h0);
    reset_n = 1'b1;
    exp_ack = 1'b0; exp_we = 1'b0; exp_issue = 1'b0; exp_dout = '0;
    chk_en = 1'b1;
    access(5'h02, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t5 word rd 02", 16'h7800);
    access(5'h04, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t5 word rd 04", 16'h0000);

    // back-to-back with m_access held high through ACK
    access(5'h06, 16'h1111, 1'b1, 1'b0, 1'b1);
    access(5'h0E, 16'h2222, 1'b1, 1'b0, 1'b1);
    access(5'h0E, 16'h0000, 1'b0, 1'b0, 1'b1);
    lit("t6 word rd 0E", 16'h2222);
    access(5'h06, 16'h0000, 1'b0, 1'b0, 1'b0);
    lit("t6 word rd 06", 16'h1111);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
